keyexp: RTL and testbench

KEYEXP -- requirements
Module: keyexp

---
 rtl/keyexp.sv | 124 ++++++++++++
 tb/tb_keyexp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/keyexp.sv
// SM4 key expansion: turns a 128-bit master key into 32 round keys, one round per clock.
//
// Ports:
//   CLK_i        system clock; all state changes on the rising edge
//   RST_i        asynchronous active-high reset
//   KEY_i        master key MK0..MK3, MK0 in [127:96]; sampled only on accept
//   KEY_VALID_i  expansion request; honoured only while idle, never queued
//   DEC_i        (only with KEYEXP_DEC_ORDER_EN) 1 = pack round keys in decryption order
//   RK_o         round keys; encryption order puts rk0 in [1023:992] and rk31 in [31:0]
//   RK_READY_o   one-cycle pulse marking RK_o complete
//   BUSY_o       high while an expansion is in progress (RUN and DONE)
//
// Optional feature macro: KEYEXP_DEC_ORDER_EN adds DEC_i and the reversed packing.
module keyexp (
  input  logic            CLK_i,
  input  logic            RST_i,
  input  logic [127:0]    KEY_i,
  input  logic            KEY_VALID_i,
`ifdef KEYEXP_DEC_ORDER_EN
  input  logic            DEC_i,
`endif
  output logic [1023:0]   RK_o,
  output logic            RK_READY_o,
  output logic            BUSY_o
);

  localparam logic [127:0] Fk = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  // SM4 S-box, entry b at bits [8*(255-b) +: 8].
  localparam logic [2047:0] Sbox = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q;
  logic [127:0]    kw_q;     // K window, K_i in [127:96]
  logic [1023:0]   rk_q;
  logic            dec_q;
  logic            accept;

  logic [7:0]      ck_base;
  logic [31:0]     ck, t_in, tau, rk_new;

  function automatic logic [7:0] sbox_lu(input logic [7:0] b);
    return Sbox[{~b, 3'b000} +: 8];
  endfunction

  // CK byte j of round i is 7*(4i+j) mod 256, so consecutive bytes step by 7.
  always_comb begin
    ck_base = 8'(cnt_q) * 8'd28;
    ck      = {ck_base, ck_base + 8'd7, ck_base + 8'd14, ck_base + 8'd21};
    t_in    = kw_q[95:64] ^ kw_q[63:32] ^ kw_q[31:0] ^ ck;
    tau     = {sbox_lu(t_in[31:24]), sbox_lu(t_in[23:16]),
               sbox_lu(t_in[15:8]),  sbox_lu(t_in[7:0])};
    rk_new  = kw_q[127:96] ^ tau ^ {tau[18:0], tau[31:19]} ^ {tau[8:0], tau[31:9]};
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    RK_READY_o = 1'b0;
    BUSY_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (KEY_VALID_i) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        BUSY_o = 1'b1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone: begin
        BUSY_o     = 1'b1;
        RK_READY_o = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The counter wraps 31 -> 0 exactly on the RUN-to-DONE edge.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      kw_q    <= '0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        kw_q  <= KEY_i ^ Fk;
        cnt_q <= '0;
      end else if (state_q == StRun) begin
        kw_q  <= {kw_q[95:0], rk_new};
        cnt_q <= cnt_q + 5'd1;
        if (dec_q) rk_q <= {rk_new, rk_q[1023:32]};
        else       rk_q <= {rk_q[991:0], rk_new};
      end
    end
  end

`ifdef KEYEXP_DEC_ORDER_EN
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i)       dec_q <= 1'b0;
    else if (accept) dec_q <= DEC_i;
  end
`else
  assign dec_q = 1'b0;
`endif

  assign RK_o = rk_q;

endmodule

// File: tb/tb_keyexp.sv
// Scoreboard bench for keyexp: the driver predicts accepts and pushes expected round-key
// vectors computed by a loop-level SM4 key schedule; a negedge monitor pops and compares.
module tb_keyexp;

  logic          CLK_i = 1'b0;
  logic          RST_i;
  logic [127:0]  KEY_i;
  logic          KEY_VALID_i;
  logic          dec;
  logic [1023:0] RK_o;
  logic          RK_READY_o;
  logic          BUSY_o;

  keyexp dut (
    .CLK_i       (CLK_i),
    .RST_i       (RST_i),
    .KEY_i       (KEY_i),
    .KEY_VALID_i (KEY_VALID_i),
`ifdef KEYEXP_DEC_ORDER_EN
    .DEC_i       (dec),
`endif
    .RK_o        (RK_o),
    .RK_READY_o  (RK_READY_o),
    .BUSY_o      (BUSY_o)
  );

  always #5 CLK_i = ~CLK_i;

  localparam logic [127:0] GoldKey = 128'h0123456789ABCDEFFEDCBA9876543210;

  byte unsigned sbox_t [256] = '{
    'hd6,'h90,'he9,'hfe,'hcc,'he1,'h3d,'hb7,'h16,'hb6,'h14,'hc2,'h28,'hfb,'h2c,'h05,
    'h2b,'h67,'h9a,'h76,'h2a,'hbe,'h04,'hc3,'haa,'h44,'h13,'h26,'h49,'h86,'h06,'h99,
    'h9c,'h42,'h50,'hf4,'h91,'hef,'h98,'h7a,'h33,'h54,'h0b,'h43,'hed,'hcf,'hac,'h62,
    'he4,'hb3,'h1c,'ha9,'hc9,'h08,'he8,'h95,'h80,'hdf,'h94,'hfa,'h75,'h8f,'h3f,'ha6,
    'h47,'h07,'ha7,'hfc,'hf3,'h73,'h17,'hba,'h83,'h59,'h3c,'h19,'he6,'h85,'h4f,'ha8,
    'h68,'h6b,'h81,'hb2,'h71,'h64,'hda,'h8b,'hf8,'heb,'h0f,'h4b,'h70,'h56,'h9d,'h35,
    'h1e,'h24,'h0e,'h5e,'h63,'h58,'hd1,'ha2,'h25,'h22,'h7c,'h3b,'h01,'h21,'h78,'h87,
    'hd4,'h00,'h46,'h57,'h9f,'hd3,'h27,'h52,'h4c,'h36,'h02,'he7,'ha0,'hc4,'hc8,'h9e,
    'hea,'hbf,'h8a,'hd2,'h40,'hc7,'h38,'hb5,'ha3,'hf7,'hf2,'hce,'hf9,'h61,'h15,'ha1,
    'he0,'hae,'h5d,'ha4,'h9b,'h34,'h1a,'h55,'had,'h93,'h32,'h30,'hf5,'h8c,'hb1,'he3,
    'h1d,'hf6,'he2,'h2e,'h82,'h66,'hca,'h60,'hc0,'h29,'h23,'hab,'h0d,'h53,'h4e,'h6f,
    'hd5,'hdb,'h37,'h45,'hde,'hfd,'h8e,'h2f,'h03,'hff,'h6a,'h72,'h6d,'h6c,'h5b,'h51,
    'h8d,'h1b,'haf,'h92,'hbb,'hdd,'hbc,'h7f,'h11,'hd9,'h5c,'h41,'h1f,'h10,'h5a,'hd8,
    'h0a,'hc1,'h31,'h88,'ha5,'hcd,'h7b,'hbd,'h2d,'h74,'hd0,'h12,'hb8,'he5,'hb4,'hb0,
    'h89,'h69,'h97,'h4a,'h0c,'h96,'h77,'h7e,'h65,'hb9,'hf1,'h09,'hc5,'h6e,'hc6,'h84,
    'h18,'hf0,'h7d,'hec,'h3a,'hdc,'h4d,'h20,'h79,'hee,'h5f,'h3e,'hd7,'hcb,'h39,'h48
  };

  typedef struct {
    logic [1023:0] rk;
    int            acc;
    bit            golden;
    bit            dec;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_n = 0;
  int   last_acc = -1000;

  always @(posedge CLK_i) edge_n <= edge_n + 1;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference key schedule written straight from the round equations.
  function automatic logic [1023:0] expand(input logic [127:0] mk, input bit d);
    logic [31:0] fk [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    logic [31:0] k [36];
    logic [31:0] ck, t, b;
    logic [1023:0] out;
    for (int i = 0; i < 4; i++) k[i] = mk[127 - 32 * i -: 32] ^ fk[i];
    for (int r = 0; r < 32; r++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8 * j -: 8] = 8'(((4 * r + j) * 7) % 256);
      t = k[r + 1] ^ k[r + 2] ^ k[r + 3] ^ ck;
      for (int j = 0; j < 4; j++) b[31 - 8 * j -: 8] = sbox_t[t[31 - 8 * j -: 8]];
      k[r + 4] = k[r] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
      if (d) out[1023 - 32 * (31 - r) -: 32] = k[r + 4];
      else   out[1023 - 32 * r -: 32] = k[r + 4];
    end
    return out;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Drive one cycle; predicts whether the upcoming edge accepts (34-clock key period).
  task automatic step(input bit v, input logic [127:0] k, input bit d, input bit golden);
    exp_t e;
    KEY_VALID_i = v;
    KEY_i       = k;
    dec         = d;
    if (v && !RST_i && (edge_n + 1 - last_acc >= 34)) begin
      e.rk     = expand(k, d);
      e.acc    = edge_n + 1;
      e.golden = golden;
      e.dec    = d;
      sb_q.push_back(e);
      last_acc = edge_n + 1;
    end
    @(posedge CLK_i);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit rand_dec();
`ifdef KEYEXP_DEC_ORDER_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // Monitor
  always @(negedge CLK_i) begin
    if (!RST_i) begin
      chk("busy", 64'(BUSY_o), 64'((edge_n - last_acc) >= 0 && (edge_n - last_acc) <= 32));
      if (RK_READY_o) begin
        if (sb_q.size() == 0) begin
          chk("spurious_ready", 64'(RK_READY_o), 64'd0);
        end else begin
          exp_t e;
          int bad;
          e = sb_q.pop_front();
          chk("latency", 64'(edge_n - e.acc + 1), 64'd33);
          bad = 0;
          for (int w = 31; w >= 0; w--)
            if (RK_o[1023 - 32 * w -: 32] !== e.rk[1023 - 32 * w -: 32]) bad = w;
          chk("rk_word", 64'(RK_o[1023 - 32 * bad -: 32]), 64'(e.rk[1023 - 32 * bad -: 32]));
          if (e.golden) begin
            chk("gold_top", 64'(RK_o[1023:992]), e.dec ? 64'h9124A012 : 64'hF12186F9);
            chk("gold_bot", 64'(RK_o[31:0]), e.dec ? 64'hF12186F9 : 64'h9124A012);
          end
        end
      end else if (sb_q.size() > 0 && edge_n > sb_q[0].acc + 32) begin
        chk("missing_ready", 64'(RK_READY_o), 64'd1);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    RST_i       = 1'b1;
    KEY_VALID_i = 1'b0;
    KEY_i       = '0;
    dec         = 1'b0;
    repeat (3) @(posedge CLK_i);
    #1;
    chk("rst_rk_zero", 64'(RK_o != '0), 64'd0);
    chk("rst_ready", 64'(RK_READY_o), 64'd0);
    chk("rst_busy", 64'(BUSY_o), 64'd0);

    // Golden key accepted on the first edge after release.
    RST_i = 1'b0;
    step(1'b1, GoldKey, 1'b0, 1'b1);
    repeat (40) step(1'b0, rand_key(), 1'b0, 1'b0);

    // Isolated random keys with random gaps.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rand_key(), rand_dec(), 1'b0);
      n = $urandom_range(0, 45);
      repeat (n) step(1'b0, rand_key(), rand_dec(), 1'b0);
    end
    repeat (40) step(1'b0, rand_key(), 1'b0, 1'b0);

    // Valid held high with a new key every cycle: only idle-time keys count.
    repeat (110) step(1'b1, rand_key(), rand_dec(), 1'b0);
    repeat (40) step(1'b0, rand_key(), 1'b0, 1'b0);

    // Reset during round 10 aborts the expansion.
    step(1'b1, rand_key(), rand_dec(), 1'b0);
    while (edge_n < last_acc + 10) step(1'b0, rand_key(), 1'b0, 1'b0);
    RST_i = 1'b1;
    sb_q.delete();
    last_acc = -1000;
    #1;
    chk("abort_rk_zero", 64'(RK_o != '0), 64'd0);
    chk("abort_ready", 64'(RK_READY_o), 64'd0);
    chk("abort_busy", 64'(BUSY_o), 64'd0);
    @(posedge CLK_i);
    #1;
    RST_i = 1'b0;
    step(1'b1, GoldKey, 1'b0, 1'b1);
    repeat (40) step(1'b0, rand_key(), 1'b0, 1'b0);

`ifdef KEYEXP_DEC_ORDER_EN
    step(1'b1, GoldKey, 1'b1, 1'b1);
    repeat (40) step(1'b0, rand_key(), 1'b0, 1'b0);
`endif

    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      step(1'b0, rand_key(), 1'b0, 1'b0);
      n++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
